// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: widths, polarities,
// FSM states and arbiter grant encoding.
package regfile_access_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic RESET_ACTIVE = 1'b1;
    localparam logic EN_W_ACTIVE  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RSP_HOLD = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_wbuf.sv
// One-deep writeback buffer: holds a dual-port write until the controller issues it.
// Accepts a new entry in the same cycle the held one is issued.
module regfile_wbuf
    import regfile_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_valid_i,
    output logic              wb_ready_o,
    input  logic [ADDR_W-1:0] wb_addr_1_i,
    input  logic [ADDR_W-1:0] wb_addr_2_i,
    input  logic [DATA_W-1:0] wb_data_1_i,
    input  logic [DATA_W-1:0] wb_data_2_i,
    input  logic              issue_i,
    output logic              buf_valid_o,
    output logic [ADDR_W-1:0] buf_addr_1_o,
    output logic [ADDR_W-1:0] buf_addr_2_o,
    output logic [DATA_W-1:0] buf_data_1_o,
    output logic [DATA_W-1:0] buf_data_2_o
);

    logic              valid_d, valid_q;
    logic [ADDR_W-1:0] addr_1_d, addr_1_q, addr_2_d, addr_2_q;
    logic [DATA_W-1:0] data_1_d, data_1_q, data_2_d, data_2_q;
    logic              accept;

    assign wb_ready_o = !valid_q || issue_i;
    assign accept     = wb_valid_i && wb_ready_o;

    always_comb begin
        valid_d  = valid_q;
        addr_1_d = addr_1_q;
        addr_2_d = addr_2_q;
        data_1_d = data_1_q;
        data_2_d = data_2_q;
        if (issue_i) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            valid_d  = 1'b1;
            addr_1_d = wb_addr_1_i;
            addr_2_d = wb_addr_2_i;
            // Same target on both ports: port 2 data goes on both so the result is deterministic.
            data_1_d = (wb_addr_1_i == wb_addr_2_i) ? wb_data_2_i : wb_data_1_i;
            data_2_d = wb_data_2_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ACTIVE) begin
            valid_q  <= 1'b0;
            addr_1_q <= '0;
            addr_2_q <= '0;
            data_1_q <= '0;
            data_2_q <= '0;
        end else begin
            valid_q  <= valid_d;
            addr_1_q <= addr_1_d;
            addr_2_q <= addr_2_d;
            data_1_q <= data_1_d;
            data_2_q <= data_2_d;
        end
    end

    assign buf_valid_o  = valid_q;
    assign buf_addr_1_o = addr_1_q;
    assign buf_addr_2_o = addr_2_q;
    assign buf_data_1_o = data_1_q;
    assign buf_data_2_o = data_2_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: arbitrates a buffered dual writeback against
// four-operand reads, with RAW protection and a registered read response.
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_req_valid_i,
    output logic              rd_req_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_1_i,
    input  logic [ADDR_W-1:0] rd_addr_2_i,
    input  logic [ADDR_W-1:0] rd_addr_3_i,
    input  logic [ADDR_W-1:0] rd_addr_4_i,
    output logic              rd_rsp_valid_o,
    input  logic              rd_rsp_ready_i,
    output logic [DATA_W-1:0] rd_rsp_data_1_o,
    output logic [DATA_W-1:0] rd_rsp_data_2_o,
    output logic [DATA_W-1:0] rd_rsp_data_3_o,
    output logic [DATA_W-1:0] rd_rsp_data_4_o,
    input  logic              wb_valid_i,
    output logic              wb_ready_o,
    input  logic [ADDR_W-1:0] wb_addr_1_i,
    input  logic [ADDR_W-1:0] wb_addr_2_i,
    input  logic [DATA_W-1:0] wb_data_1_i,
    input  logic [DATA_W-1:0] wb_data_2_i,
    output logic              en_w_reg_o,
    output logic [ADDR_W-1:0] w_reg_addr_1_o,
    output logic [ADDR_W-1:0] w_reg_addr_2_o,
    output logic [DATA_W-1:0] w_reg_data_1_o,
    output logic [DATA_W-1:0] w_reg_data_2_o,
    output logic [ADDR_W-1:0] r_reg_addr_1_o,
    output logic [ADDR_W-1:0] r_reg_addr_2_o,
    output logic [ADDR_W-1:0] r_reg_addr_3_o,
    output logic [ADDR_W-1:0] r_reg_addr_4_o,
    input  logic [DATA_W-1:0] r_reg_data_1_i,
    input  logic [DATA_W-1:0] r_reg_data_2_i,
    input  logic [DATA_W-1:0] r_reg_data_3_i,
    input  logic [DATA_W-1:0] r_reg_data_4_i
);

    state_e                   state_d, state_q;
    grant_e                   last_grant_d, last_grant_q;
    logic [3:0][ADDR_W-1:0]   r_addr_d, r_addr_q;
    logic [3:0][DATA_W-1:0]   rsp_data_d, rsp_data_q;
    logic [3:0][ADDR_W-1:0]   rd_addr;
    logic [3:0][DATA_W-1:0]   r_data;
    logic                     buf_valid;
    logic [ADDR_W-1:0]        buf_addr_1, buf_addr_2;
    logic [DATA_W-1:0]        buf_data_1, buf_data_2;
    logic                     wr_issue, rd_issue, raw_hit, run;

    assign rd_addr = {rd_addr_4_i, rd_addr_3_i, rd_addr_2_i, rd_addr_1_i};
    assign r_data  = {r_reg_data_4_i, r_reg_data_3_i, r_reg_data_2_i, r_reg_data_1_i};
    assign run     = (rst_i != RESET_ACTIVE);

    regfile_wbuf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wb_valid_i   (wb_valid_i),
        .wb_ready_o   (wb_ready_o),
        .wb_addr_1_i  (wb_addr_1_i),
        .wb_addr_2_i  (wb_addr_2_i),
        .wb_data_1_i  (wb_data_1_i),
        .wb_data_2_i  (wb_data_2_i),
        .issue_i      (wr_issue),
        .buf_valid_o  (buf_valid),
        .buf_addr_1_o (buf_addr_1),
        .buf_addr_2_o (buf_addr_2),
        .buf_data_1_o (buf_data_1),
        .buf_data_2_o (buf_data_2)
    );

    always_comb begin
        raw_hit = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (rd_addr[k] == buf_addr_1 || rd_addr[k] == buf_addr_2) begin
                raw_hit = 1'b1;
            end
        end
        raw_hit = raw_hit && buf_valid && rd_req_valid_i;
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        r_addr_d       = r_addr_q;
        rsp_data_d     = rsp_data_q;
        wr_issue       = 1'b0;
        rd_issue       = 1'b0;
        rd_req_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A read only pre-empts a pending write when the write had the last grant
                // and the read does not touch the buffered addresses.
                wr_issue       = run && buf_valid &&
                                 (raw_hit || !(rd_req_valid_i && last_grant_q == GRANT_WR));
                rd_req_ready_o = !wr_issue;
                rd_issue       = run && rd_req_valid_i && !wr_issue;
                if (rd_issue) begin
                    r_addr_d     = rd_addr;
                    last_grant_d = GRANT_RD;
                    state_d      = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                rsp_data_d = r_data;
                state_d    = ST_RSP_HOLD;
            end
            ST_RSP_HOLD: begin
                wr_issue = run && buf_valid;
                if (rd_rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_issue) begin
            last_grant_d = GRANT_WR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ACTIVE) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_RD;
            r_addr_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            r_addr_q     <= r_addr_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign en_w_reg_o     = wr_issue ? EN_W_ACTIVE : ~EN_W_ACTIVE;
    assign w_reg_addr_1_o = wr_issue ? buf_addr_1 : '0;
    assign w_reg_addr_2_o = wr_issue ? buf_addr_2 : '0;
    assign w_reg_data_1_o = wr_issue ? buf_data_1 : '0;
    assign w_reg_data_2_o = wr_issue ? buf_data_2 : '0;

    assign r_reg_addr_1_o = r_addr_d[0];
    assign r_reg_addr_2_o = r_addr_d[1];
    assign r_reg_addr_3_o = r_addr_d[2];
    assign r_reg_addr_4_o = r_addr_d[3];

    assign rd_rsp_valid_o  = (state_q == ST_RSP_HOLD);
    assign rd_rsp_data_1_o = rsp_data_q[0];
    assign rd_rsp_data_2_o = rsp_data_q[1];
    assign rd_rsp_data_3_o = rsp_data_q[2];
    assign rd_rsp_data_4_o = rsp_data_q[3];

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// End-to-end bench: controller driving a behavioural register file, with a
// scoreboard of expected read responses built from accepted writebacks.
module tb_regfile_access_ctrl;

    localparam int DW = 8;
    localparam int AW = 5;

    typedef struct {
        logic [3:0][DW-1:0] d;
        int                 cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_req_valid = 1'b0;
    logic rd_req_ready;
    logic [3:0][AW-1:0] rd_addr = '0;
    logic rd_rsp_valid;
    logic rd_rsp_ready = 1'b1;
    logic [3:0][DW-1:0] rsp_data;
    logic wb_valid = 1'b0;
    logic wb_ready;
    logic [AW-1:0] wb_a1 = '0, wb_a2 = '0;
    logic [DW-1:0] wb_d1 = '0, wb_d2 = '0;
    logic en_w;
    logic [AW-1:0] w_a1, w_a2;
    logic [DW-1:0] w_d1, w_d2;
    logic [3:0][AW-1:0] r_addr;
    logic [3:0][DW-1:0] r_data;

    logic [DW-1:0] mem [32] = '{default: '0};
    logic [DW-1:0] ref_mem [32];
    rsp_t exp_q[$];
    rsp_t obs_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready),
        .rd_addr_1_i(rd_addr[0]), .rd_addr_2_i(rd_addr[1]),
        .rd_addr_3_i(rd_addr[2]), .rd_addr_4_i(rd_addr[3]),
        .rd_rsp_valid_o(rd_rsp_valid), .rd_rsp_ready_i(rd_rsp_ready),
        .rd_rsp_data_1_o(rsp_data[0]), .rd_rsp_data_2_o(rsp_data[1]),
        .rd_rsp_data_3_o(rsp_data[2]), .rd_rsp_data_4_o(rsp_data[3]),
        .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
        .wb_addr_1_i(wb_a1), .wb_addr_2_i(wb_a2),
        .wb_data_1_i(wb_d1), .wb_data_2_i(wb_d2),
        .en_w_reg_o(en_w),
        .w_reg_addr_1_o(w_a1), .w_reg_addr_2_o(w_a2),
        .w_reg_data_1_o(w_d1), .w_reg_data_2_o(w_d2),
        .r_reg_addr_1_o(r_addr[0]), .r_reg_addr_2_o(r_addr[1]),
        .r_reg_addr_3_o(r_addr[2]), .r_reg_addr_4_o(r_addr[3]),
        .r_reg_data_1_i(r_data[0]), .r_reg_data_2_i(r_data[1]),
        .r_reg_data_3_i(r_data[2]), .r_reg_data_4_i(r_data[3])
    );

    // Register file: registered read, reads return 0 in a write cycle.
    always @(posedge clk) begin
        if (en_w) begin
            mem[w_a1] <= w_d1;
            mem[w_a2] <= w_d2;
        end
        for (int k = 0; k < 4; k++) r_data[k] <= en_w ? '0 : mem[r_addr[k]];
    end

    // Scoreboard feed: a read sees every writeback accepted strictly before it.
    initial begin
        rsp_t e, o;
        int   first_cyc;
        logic rsp_prev;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        first_cyc = 0;
        rsp_prev  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (rd_req_valid && rd_req_ready) begin
                    for (int k = 0; k < 4; k++) e.d[k] = ref_mem[rd_addr[k]];
                    e.cyc = cyc;
                    exp_q.push_back(e);
                end
                if (wb_valid && wb_ready) begin
                    ref_mem[wb_a1] = wb_d1;
                    ref_mem[wb_a2] = wb_d2;
                end
                if (rd_rsp_valid && !rsp_prev) first_cyc = cyc;
                if (rd_rsp_valid && rd_rsp_ready) begin
                    o.d   = rsp_data;
                    o.cyc = first_cyc;
                    obs_q.push_back(o);
                end
            end
            rsp_prev = rd_rsp_valid && !rst;
        end
    end

    task automatic drive_write(input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic [AW-1:0] a2, input logic [DW-1:0] d2, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_a1 = a1; wb_d1 = d1; wb_a2 = a2; wb_d2 = d2;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (wb_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    task automatic drive_read(input logic [3:0][AW-1:0] a, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        rd_req_valid = 1'b1; rd_addr = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rd_req_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (obs_q.size() >= n) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rd_rsp_valid); end
        n_cmp++; if (en_w !== 1'b0) begin n_fail++; $display("FAIL reset_en_w: got %b required 0", en_w); end
        n_cmp++; if ({w_a1, w_a2, w_d1, w_d2} !== '0) begin n_fail++; $display("FAIL reset_wport: got %h required 0", {w_a1, w_a2, w_d1, w_d2}); end
        n_cmp++; if (r_addr !== '0) begin n_fail++; $display("FAIL reset_raddr: got %h required 0", r_addr); end
        n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data); end
        n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready: got %b required 1", wb_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        rsp_t e, o;
        drive_write(5'd3, 8'h5A, 5'd4, 8'hA5, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_wb_accept: got no accept, required accept"); end
        drive_read({5'd3, 5'd0, 5'd4, 5'd3}, ok);
        wait_rsp(1, ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL basic_rsp: got %0d responses required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o.d !== e.d) begin n_fail++; $display("FAIL basic_data: got %h required %h", o.d, e.d); end
            n_cmp++; if (o.cyc - e.cyc !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d required 2", o.cyc - e.cyc); end
        end
    endtask

    task automatic test_raw();
        bit ok;
        rsp_t e, o;
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_a1 = 5'd20; wb_d1 = 8'h33; wb_a2 = 5'd21; wb_d2 = 8'h44;
        @(negedge clk);
        n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_accept: got %b required 1", wb_ready); end
        @(posedge clk); #1;
        wb_a1 = 5'd7; wb_d1 = 8'h11; wb_a2 = 5'd8; wb_d2 = 8'h22;
        @(negedge clk);
        n_cmp++; if ({en_w, wb_ready} !== 2'b11) begin n_fail++; $display("FAIL raw_issue_and_refill: got %b required 11", {en_w, wb_ready}); end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        rd_req_valid = 1'b1; rd_addr = {5'd21, 5'd20, 5'd8, 5'd7};
        @(negedge clk);
        n_cmp++; if ({en_w, rd_req_ready} !== 2'b10) begin n_fail++; $display("FAIL raw_write_first: got %b required 10", {en_w, rd_req_ready}); end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rd_req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        wait_rsp(1, ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL raw_rsp: got %0d responses required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o.d !== e.d) begin n_fail++; $display("FAIL raw_data: got %h required %h", o.d, e.d); end
        end
    endtask

    task automatic test_same_addr();
        bit ok;
        rsp_t e, o;
        drive_write(5'd9, 8'h01, 5'd9, 8'h02, ok);
        drive_read({5'd9, 5'd9, 5'd9, 5'd9}, ok);
        wait_rsp(1, ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL same_addr_rsp: got %0d responses required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o.d !== e.d) begin n_fail++; $display("FAIL same_addr_data: got %h required %h", o.d, e.d); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        rsp_t e, o;
        @(posedge clk); #1;
        rd_rsp_ready = 1'b0;
        drive_read({5'd20, 5'd9, 5'd4, 5'd3}, ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rd_rsp_valid) ok = 1'b1;
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_valid: got 0 required 1"); end
        @(posedge clk); #1;
        rd_req_valid = 1'b1; rd_addr = {5'd8, 5'd7, 5'd21, 5'd3};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (rd_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b required 1", rd_rsp_valid); end
            n_cmp++; if (rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready: got %b required 0", rd_req_ready); end
            if (exp_q.size() > 0) begin
                n_cmp++; if (rsp_data !== exp_q[0].d) begin n_fail++; $display("FAIL bp_hold_data: got %h required %h", rsp_data, exp_q[0].d); end
            end
        end
        @(posedge clk); #1;
        rd_rsp_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rd_req_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        wait_rsp(2, ok);
        n_cmp++;
        if (!ok || exp_q.size() < 2) begin
            n_fail++; $display("FAIL bp_rsp: got %0d responses required 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                n_cmp++; if (o.d !== e.d) begin n_fail++; $display("FAIL bp_data%0d: got %h required %h", i, o.d, e.d); end
            end
        end
    endtask

    task automatic test_contention();
        bit ok, have_last, last_w, in_rd_wait, g_w, g_r, wb_acc;
        int n;
        rsp_t e, o;
        drive_write(5'd16, 8'h61, 5'd17, 8'h72, ok);
        drive_write(5'd18, 8'h83, 5'd19, 8'h94, ok);
        @(posedge clk); #1;
        wb_valid = 1'b1;
        wb_a1 = AW'(10 + $urandom_range(0, 5)); wb_d1 = DW'($urandom);
        wb_a2 = AW'(10 + $urandom_range(0, 5)); wb_d2 = DW'($urandom);
        rd_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) rd_addr[k] = AW'(16 + $urandom_range(0, 3));
        have_last = 1'b0; last_w = 1'b0; in_rd_wait = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            g_w = en_w;
            g_r = rd_req_valid && rd_req_ready;
            n_cmp++; if (g_w && g_r) begin n_fail++; $display("FAIL cont_exclusive: got write+read required one"); end
            n_cmp++; if (in_rd_wait && g_w) begin n_fail++; $display("FAIL cont_rd_wait_write: got en_w 1 required 0"); end
            if (g_w || g_r) begin
                if (have_last) begin
                    n_cmp++; if (g_w == last_w) begin n_fail++; $display("FAIL cont_alternate: got repeat grant w=%b required alternation", g_w); end
                end
                have_last = 1'b1; last_w = g_w;
            end
            in_rd_wait = g_r;
            wb_acc = wb_valid && wb_ready;
            @(posedge clk); #1;
            if (wb_acc) begin
                wb_a1 = AW'(10 + $urandom_range(0, 5)); wb_d1 = DW'($urandom);
                wb_a2 = AW'(10 + $urandom_range(0, 5)); wb_d2 = DW'($urandom);
            end
            if (g_r) for (int k = 0; k < 4; k++) rd_addr[k] = AW'(16 + $urandom_range(0, 3));
        end
        wb_valid = 1'b0; rd_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n = exp_q.size();
        wait_rsp(n, ok);
        n_cmp++;
        if (!ok || n < 3) begin
            n_fail++; $display("FAIL cont_rsp: got %0d of %0d responses, required at least 3 all delivered", obs_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                n_cmp++; if (o.d !== e.d) begin n_fail++; $display("FAIL cont_data%0d: got %h required %h", i, o.d, e.d); end
            end
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        rsp_t e, o;
        logic [DW-1:0] old25, old26;
        old25 = ref_mem[25]; old26 = ref_mem[26];
        @(posedge clk); #1;
        rd_req_valid = 1'b1; rd_addr = {5'd25, 5'd9, 5'd4, 5'd3};
        wb_valid = 1'b1; wb_a1 = 5'd25; wb_d1 = 8'hEE; wb_a2 = 5'd26; wb_d2 = 8'hDD;
        @(negedge clk);
        n_cmp++; if ({rd_req_ready, wb_ready} !== 2'b11) begin n_fail++; $display("FAIL rmid_accept: got %b required 11", {rd_req_ready, wb_ready}); end
        @(posedge clk); #1;
        rd_req_valid = 1'b0; wb_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rd_rsp_valid, en_w} !== 2'b00) begin n_fail++; $display("FAIL rmid_valid_en: got %b required 00", {rd_rsp_valid, en_w}); end
        n_cmp++; if ({w_a1, w_a2, w_d1, w_d2} !== '0) begin n_fail++; $display("FAIL rmid_wport: got %h required 0", {w_a1, w_a2, w_d1, w_d2}); end
        n_cmp++; if (r_addr !== '0) begin n_fail++; $display("FAIL rmid_raddr: got %h required 0", r_addr); end
        n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("FAIL rmid_rsp_data: got %h required 0", rsp_data); end
        n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_buf_empty: got %b required 1", wb_ready); end
        ref_mem[25] = old25; ref_mem[26] = old26;
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++; if ({rd_rsp_valid, en_w} !== 2'b00) begin n_fail++; $display("FAIL rmid_quiet: got %b required 00", {rd_rsp_valid, en_w}); end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid_no_rsp: got %0d responses required 0", obs_q.size()); end
        obs_q.delete();
        drive_read({5'd4, 5'd3, 5'd26, 5'd25}, ok);
        wait_rsp(1, ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL rmid_rsp: got %0d responses required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o.d !== e.d) begin n_fail++; $display("FAIL rmid_regs_unchanged: got %h required %h", o.d, e.d); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_same_addr();
        test_backpressure();
        test_contention();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width (32 entries).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 rd_req_valid_i / rd_req_ready_o  input/output  1/1  operand-read request handshake.
REQ-006 rd_addr_1_i..rd_addr_4_i  input  ADDR_W each  four operand addresses, sampled on read acceptance.
REQ-007 rd_rsp_valid_o / rd_rsp_ready_i  output/input  1/1  read-response handshake.
REQ-008 rd_rsp_data_1_o..rd_rsp_data_4_o  output  DATA_W each  operand data, one per read address.
REQ-009 wb_valid_i / wb_ready_o  input/output  1/1  writeback request handshake.
REQ-010 wb_addr_1_i, wb_addr_2_i  input  ADDR_W each; wb_data_1_i, wb_data_2_i  input  DATA_W each  dual writeback.
REQ-011 en_w_reg_o  output  1  register-file write enable (high = write cycle).
REQ-012 w_reg_addr_1_o, w_reg_addr_2_o  output  ADDR_W; w_reg_data_1_o, w_reg_data_2_o  output  DATA_W  write port drive.
REQ-013 r_reg_addr_1_o..r_reg_addr_4_o  output  ADDR_W; r_reg_data_1_i..r_reg_data_4_i  input  DATA_W  read port; register file registers read data one cycle after address, and returns 0 in any cycle en_w_reg_o is high.

Function
REQ-014 One-deep write buffer SHALL hold an accepted writeback; wb_ready_o = buffer empty OR buffer issuing this cycle.
REQ-015 Per cycle in IDLE, at most one of {write issue, read issue}; never both (register file cannot read during write).
REQ-016 Arbitration: buffered write issues unless a read request is valid AND last grant was write; then read issues (strict alternation under contention).
REQ-017 RAW hazard: if any rd_addr_k_i equals a valid buffered write address, write SHALL issue first regardless of alternation.
REQ-018 A writeback accepted in the same cycle as a read is ordered after that read (read returns old value).
REQ-019 Read issue: rd_req_ready_o=1, r_reg_addr_k_o driven from rd_addr_k_i, FSM IDLE->RD_WAIT.
REQ-020 RD_WAIT: en_w_reg_o=0; r_reg_data_k_i captured into response registers; FSM->RSP_HOLD, rd_rsp_valid_o=1 next cycle (acceptance-to-valid latency 2 cycles).
REQ-021 RSP_HOLD: data stable while rd_rsp_valid_o && !rd_rsp_ready_i; on ready FSM->IDLE; writes may issue in RD_WAIT/RSP_HOLD only if not RD_WAIT.
REQ-022 rd_req_ready_o SHALL be 0 outside IDLE.
REQ-023 Write issue: en_w_reg_o=1 for exactly one cycle, buffered addresses/data on write port, buffer cleared.
REQ-024 If wb_addr_1_i == wb_addr_2_i, both write ports SHALL carry wb_data_2_i (port 2 wins deterministically).
REQ-025 r_reg_addr_k_o SHALL hold last value when not issuing a read.

Reset
REQ-026 On rst_i: FSM=IDLE, buffer empty, last grant=read, en_w_reg_o=0, rd_rsp_valid_o=0, all data/address outputs 0.
REQ-027 Reset mid-operation SHALL discard buffered write and in-flight read; no response emitted afterwards.

Structure
REQ-028 DATA_W, ADDR_W defaults, RESET and EN_W polarity constants and FSM state encodings SHALL live in shared defs.v.
REQ-029 Write buffer SHALL be sub-module regfile_wbuf; FSM and arbiter remain in top.
REQ-030 Bench SHALL instantiate this block driving register module for end-to-end checks.

Verification
REQ-031 Write (3<-0x5A, 4<-0xA5), then read {3,4,0,3} -> response {0x5A,0xA5,0x00,0x5A}, valid exactly 2 cycles after read acceptance.
REQ-032 Buffered write to 7 (0x11) pending, last grant write, read of 7 arrives -> write issues first, read returns 0x11.
REQ-033 Continuous wb_valid_i and rd_req_valid_i for 10 cycles -> grants alternate; en_w_reg_o never high during RD_WAIT.
REQ-034 wb_addr_1_i=wb_addr_2_i=9, data 0x01/0x02 -> register 9 reads 0x02.
REQ-035 rd_rsp_ready_i low 5 cycles -> response data unchanged, rd_req_ready_o=0 throughout.
REQ-036 rst_i asserted in RD_WAIT with write buffered -> next cycle all outputs 0, no response, register contents unchanged by controller.
